// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// controller states, forward-source encodings, the hard-wired zero register,
// and a helper that decides whether a pipeline stage writes an ID source.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } hazState_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b11;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Wide enough for any legal wait limit (1..255).
    localparam int WAIT_CNT_W = 8;

    // True when a used, non-x0 source register is written by a stage.
    function automatic logic regHit(
        input logic [4:0] src,
        input logic       used,
        input logic       we,
        input logic [4:0] dst
    );
        return used && we && (src != REG_X0) && (src == dst);
    endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Per-operand forwarding selector: picks the youngest stage that writes the
// operand's source register. A load still in EX cannot supply its data yet,
// so a match against it is reported as a load hit and forces no forwarding.
module fwd_sel_unit
    import hazard_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       srcUsed_i,
    input  logic [4:0] exWr_i,
    input  logic       exWe_i,
    input  logic       exIsLoad_i,
    input  logic [4:0] memWr_i,
    input  logic       memWe_i,
    input  logic [4:0] wbWr_i,
    input  logic       wbWe_i,
    output logic [1:0] fwdSel_o,
    output logic       fwdOp_o,
    output logic       loadHit_o
);

    logic exHit;
    logic memHit;
    logic wbHit;

    assign exHit  = regHit(src_i, srcUsed_i, exWe_i, exWr_i);
    assign memHit = regHit(src_i, srcUsed_i, memWe_i, memWr_i);
    assign wbHit  = regHit(src_i, srcUsed_i, wbWe_i, wbWr_i);

    // Priority match EX > MEM > WB, with an EX load blocking all forwarding.
    always_comb begin
        fwdSel_o  = FWD_NONE;
        loadHit_o = 1'b0;
        if (exHit && exIsLoad_i) begin
            loadHit_o = 1'b1;
        end else if (exHit) begin
            fwdSel_o = FWD_EX;
        end else if (memHit) begin
            fwdSel_o = FWD_MEM;
        end else if (wbHit) begin
            fwdSel_o = FWD_WB;
        end
    end

    assign fwdOp_o = (fwdSel_o != FWD_NONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage core.
// Produces stall/flush controls and ID-stage forwarding selects, and walks
// multi-cycle DRAM accesses through a RUN/WAIT/ERR sequence with a timeout.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush cycle
// counters on ports perf_stall_cnt and perf_flush_cnt.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_wR,
    input  logic       ex_rf_we,
    input  logic       ex_is_load,
    input  logic [4:0] mem_wR,
    input  logic       mem_rf_we,
    input  logic [4:0] wb_wR,
    input  logic       wb_rf_we,
    input  logic       ex_redirect,
    input  logic       mem_dram_req,
    input  logic       dram_ack,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       id_ex_flush,
    output logic       ex_mem_stall,
    output logic       rD1_op,
    output logic       rD2_op,
    output logic [1:0] rD1_fwd_sel,
    output logic [1:0] rD2_fwd_sel,
    output logic       mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : gBadWaitMax
        $error("hazard_ctrl: WAIT_MAX must lie within 1..255");
    end
    if (CNT_W < 1) begin : gBadCntW
        $error("hazard_ctrl: CNT_W must be at least 1");
    end

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(WAIT_MAX);

    hazState_e             state_q;
    hazState_e             state_d;
    logic [WAIT_CNT_W-1:0] waitCnt_q;
    logic [WAIT_CNT_W-1:0] waitCnt_d;
    logic                  timeout_q;
    logic                  timeout_d;

    logic [1:0] fwdSel1;
    logic [1:0] fwdSel2;
    logic       fwdOp1;
    logic       fwdOp2;
    logic       loadHit1;
    logic       loadHit2;

    fwd_sel_unit u_fwdRs1 (
        .src_i      (id_rs1),
        .srcUsed_i  (id_rs1_used),
        .exWr_i     (ex_wR),
        .exWe_i     (ex_rf_we),
        .exIsLoad_i (ex_is_load),
        .memWr_i    (mem_wR),
        .memWe_i    (mem_rf_we),
        .wbWr_i     (wb_wR),
        .wbWe_i     (wb_rf_we),
        .fwdSel_o   (fwdSel1),
        .fwdOp_o    (fwdOp1),
        .loadHit_o  (loadHit1)
    );

    fwd_sel_unit u_fwdRs2 (
        .src_i      (id_rs2),
        .srcUsed_i  (id_rs2_used),
        .exWr_i     (ex_wR),
        .exWe_i     (ex_rf_we),
        .exIsLoad_i (ex_is_load),
        .memWr_i    (mem_wR),
        .memWe_i    (mem_rf_we),
        .wbWr_i     (wb_wR),
        .wbWe_i     (wb_rf_we),
        .fwdSel_o   (fwdSel2),
        .fwdOp_o    (fwdOp2),
        .loadHit_o  (loadHit2)
    );

    // Controller state, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            waitCnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state and all pipeline controls; memory sequencing outranks
    // redirects, which outrank load-use bubbles.
    always_comb begin
        state_d      = state_q;
        waitCnt_d    = waitCnt_q;
        timeout_d    = timeout_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        rD1_op       = 1'b0;
        rD2_op       = 1'b0;
        rD1_fwd_sel  = FWD_NONE;
        rD2_fwd_sel  = FWD_NONE;

        if (rst) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_dram_req && !dram_ack) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                        state_d      = WAIT;
                        waitCnt_d    = WAIT_CNT_W'(1);
                    end else begin
                        rD1_op      = fwdOp1;
                        rD2_op      = fwdOp2;
                        rD1_fwd_sel = fwdSel1;
                        rD2_fwd_sel = fwdSel2;
                        if (ex_redirect) begin
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end else if (loadHit1 || loadHit2) begin
                            pc_stall    = 1'b1;
                            if_id_stall = 1'b1;
                            id_ex_flush = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    if (dram_ack) begin
                        state_d   = RUN;
                        waitCnt_d = '0;
                    end else if (waitCnt_q == WAIT_LIMIT) begin
                        state_d   = ERR;
                        timeout_d = 1'b1;
                    end else begin
                        waitCnt_d = waitCnt_q + WAIT_CNT_W'(1);
                    end
                end
                default: begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                end
            endcase
        end
    end

    assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perfStall_q;
    logic [CNT_W-1:0] perfFlush_q;

    // Saturating counts of PC-stall and ID/EX-flush cycles since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perfStall_q <= '0;
            perfFlush_q <= '0;
        end else begin
            if (pc_stall && (perfStall_q != {CNT_W{1'b1}})) begin
                perfStall_q <= perfStall_q + CNT_W'(1);
            end
            if (id_ex_flush && (perfFlush_q != {CNT_W{1'b1}})) begin
                perfFlush_q <= perfFlush_q + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt = perfStall_q;
    assign perf_flush_cnt = perfFlush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus a randomized run, all
// checked against a behavioural model of the hazard rules kept here.
// Build with HAZARD_PERF_EN defined to also check the perf counters.
module tb_hazard_ctrl;

    localparam int WAIT_MAX_TB = 4;
    localparam int CNT_W_TB    = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_wR, mem_wR, wb_wR;
    logic       id_rs1_used, id_rs2_used, ex_rf_we, ex_is_load;
    logic       mem_rf_we, wb_rf_we, ex_redirect, mem_dram_req, dram_ack;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic       ex_mem_stall, rD1_op, rD2_op, mem_timeout;
    logic [1:0] rD1_fwd_sel, rD2_fwd_sel;
`ifdef HAZARD_PERF_EN
    logic [CNT_W_TB-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] stallVec;
    logic [1:0] flushVec;
    logic [5:0] fwdVec;
    assign stallVec = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall};
    assign flushVec = {if_id_flush, id_ex_flush};
    assign fwdVec   = {rD1_op, rD1_fwd_sel, rD2_op, rD2_fwd_sel};

    hazard_ctrl #(.WAIT_MAX(WAIT_MAX_TB), .CNT_W(CNT_W_TB)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .ex_wR        (ex_wR),
        .ex_rf_we     (ex_rf_we),
        .ex_is_load   (ex_is_load),
        .mem_wR       (mem_wR),
        .mem_rf_we    (mem_rf_we),
        .wb_wR        (wb_wR),
        .wb_rf_we     (wb_rf_we),
        .ex_redirect  (ex_redirect),
        .mem_dram_req (mem_dram_req),
        .dram_ack     (dram_ack),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_stall (ex_mem_stall),
        .rD1_op       (rD1_op),
        .rD2_op       (rD2_op),
        .rD1_fwd_sel  (rD1_fwd_sel),
        .rD2_fwd_sel  (rD2_fwd_sel),
        .mem_timeout  (mem_timeout)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model state: access outstanding, cycles waited, timed out.
    bit          mBusy;
    bit          mErr;
    int          mWaited;
    logic [31:0] mStall;
    logic [31:0] mFlush;

    typedef struct packed {
        logic [3:0] stalls;
        logic [1:0] flushes;
        logic [5:0] fwd;
    } expect_t;

    // Youngest stage (EX, MEM, WB order) able to supply a source register.
    function automatic logic [1:0] youngestWriter(input logic [4:0] src, input logic used);
        logic [4:0] dst  [3];
        logic       wr   [3];
        logic [1:0] code [3];
        if (!used || src == 5'd0) return 2'b00;
        dst[0] = ex_wR;  wr[0] = ex_rf_we && !ex_is_load; code[0] = 2'b01;
        dst[1] = mem_wR; wr[1] = mem_rf_we;               code[1] = 2'b10;
        dst[2] = wb_wR;  wr[2] = wb_rf_we;                code[2] = 2'b11;
        for (int k = 0; k < 3; k++) begin
            if (wr[k] && dst[k] == src) return code[k];
        end
        return 2'b00;
    endfunction

    function automatic logic loadBlocks(input logic [4:0] src, input logic used);
        return used && src != 5'd0 && ex_is_load && ex_rf_we && ex_wR == src;
    endfunction

    // Expected combinational outputs from the current inputs and model state.
    function automatic expect_t predict();
        expect_t    p;
        logic       lu1, lu2;
        logic [1:0] s1, s2;
        p = '0;
        if (rst) begin
            p.flushes = 2'b11;
        end else if (mErr || mBusy || (mem_dram_req && !dram_ack)) begin
            p.stalls = 4'b1111;
        end else begin
            lu1 = loadBlocks(id_rs1, id_rs1_used);
            lu2 = loadBlocks(id_rs2, id_rs2_used);
            s1  = lu1 ? 2'b00 : youngestWriter(id_rs1, id_rs1_used);
            s2  = lu2 ? 2'b00 : youngestWriter(id_rs2, id_rs2_used);
            p.fwd = {s1 != 2'b00, s1, s2 != 2'b00, s2};
            if (ex_redirect) begin
                p.flushes = 2'b11;
            end else if (lu1 || lu2) begin
                p.stalls  = 4'b1100;
                p.flushes = 2'b01;
            end
        end
        return p;
    endfunction

    // Advance the model on every rising edge using the inputs seen there.
    always @(posedge clk) begin : modelStep
        expect_t e;
        e = predict();
        if (rst) begin
            mBusy = 0; mErr = 0; mWaited = 0; mStall = '0; mFlush = '0;
        end else begin
            if (e.stalls[3] && mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
            if (e.flushes[0] && mFlush != 32'hFFFF_FFFF) mFlush = mFlush + 32'd1;
            if (mErr) begin
                mErr = 1;
            end else if (mBusy) begin
                if (dram_ack) begin
                    mBusy = 0; mWaited = 0;
                end else begin
                    mWaited++;
                    if (mWaited == WAIT_MAX_TB) begin
                        mErr = 1; mBusy = 0;
                    end
                end
            end else if (mem_dram_req && !dram_ack) begin
                mBusy = 1; mWaited = 0;
            end
        end
    end

    task automatic idleInputs();
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
        ex_wR = '0; ex_rf_we = 0; ex_is_load = 0;
        mem_wR = '0; mem_rf_we = 0; wb_wR = '0; wb_rf_we = 0;
        ex_redirect = 0; mem_dram_req = 0; dram_ack = 0;
    endtask

    // Drive a load in EX writing x7 that the ID instruction reads as rs2.
    task automatic applyStimulus();
        idleInputs();
        ex_wR = 5'd7; ex_rf_we = 1; ex_is_load = 1;
        id_rs2 = 5'd7; id_rs2_used = 1;
        id_rs1 = 5'd3; id_rs1_used = 1;
        mem_wR = 5'd7; mem_rf_we = 1;
        wb_wR = 5'd7;  wb_rf_we = 1;
    endtask

    task automatic test_reset();
        rst = 1; idleInputs(); #1;
        checks++; if (stallVec !== 4'b0000) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0000", stallVec); end
        checks++; if (flushVec !== 2'b11) begin errors++; $display("[TB] FAIL reset_flush: got %b expected 11", flushVec); end
        checks++; if (fwdVec !== 6'b0) begin errors++; $display("[TB] FAIL reset_fwd: got %b expected 000000", fwdVec); end
        @(negedge clk); #1;
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", mem_timeout); end
        @(negedge clk); rst = 0; #1;
        checks++; if ({stallVec, flushVec, fwdVec} !== 12'b0) begin errors++; $display("[TB] FAIL reset_release: got %b expected all zero", {stallVec, flushVec, fwdVec}); end
    endtask

    task automatic test_forward_priority();
        @(negedge clk); idleInputs();
        id_rs1 = 5'd5; id_rs1_used = 1;
        ex_wR = 5'd5; ex_rf_we = 1; mem_wR = 5'd5; mem_rf_we = 1; wb_wR = 5'd5; wb_rf_we = 1; #1;
        checks++; if (fwdVec !== 6'b101_000) begin errors++; $display("[TB] FAIL fwd_ex: got %b expected 101000", fwdVec); end
        checks++; if (stallVec !== 4'b0000) begin errors++; $display("[TB] FAIL fwd_nostall: got %b expected 0000", stallVec); end
        @(negedge clk); ex_rf_we = 0; #1;
        checks++; if (fwdVec !== 6'b110_000) begin errors++; $display("[TB] FAIL fwd_mem: got %b expected 110000", fwdVec); end
        @(negedge clk); mem_rf_we = 0; #1;
        checks++; if (fwdVec !== 6'b111_000) begin errors++; $display("[TB] FAIL fwd_wb: got %b expected 111000", fwdVec); end
        @(negedge clk); ex_rf_we = 1; mem_rf_we = 1; id_rs1 = 5'd0; #1;
        checks++; if (fwdVec !== 6'b000_000) begin errors++; $display("[TB] FAIL fwd_x0: got %b expected 000000", fwdVec); end
        @(negedge clk); id_rs2 = 5'd5; id_rs2_used = 1; #1;
        checks++; if (fwdVec !== 6'b000_101) begin errors++; $display("[TB] FAIL fwd_rs2_ex: got %b expected 000101", fwdVec); end
        @(negedge clk); id_rs2_used = 0; #1;
        checks++; if (fwdVec !== 6'b000_000) begin errors++; $display("[TB] FAIL fwd_unused: got %b expected 000000", fwdVec); end
    endtask

    task automatic test_load_use();
        @(negedge clk); applyStimulus(); #1;
        checks++; if (stallVec !== 4'b1100) begin errors++; $display("[TB] FAIL loaduse_stall: got %b expected 1100", stallVec); end
        checks++; if (flushVec !== 2'b01) begin errors++; $display("[TB] FAIL loaduse_flush: got %b expected 01", flushVec); end
        checks++; if (fwdVec !== 6'b000_000) begin errors++; $display("[TB] FAIL loaduse_fwd: got %b expected 000000", fwdVec); end
        @(negedge clk);
        ex_rf_we = 0; ex_is_load = 0; ex_wR = 5'd0; wb_wR = 5'd9; #1;
        checks++; if (stallVec !== 4'b0000) begin errors++; $display("[TB] FAIL loaduse_next_stall: got %b expected 0000", stallVec); end
        checks++; if (fwdVec !== 6'b000_110) begin errors++; $display("[TB] FAIL loaduse_next_fwd: got %b expected 000110", fwdVec); end
    endtask

    task automatic test_redirect();
        @(negedge clk); applyStimulus(); ex_redirect = 1; #1;
        checks++; if (flushVec !== 2'b11) begin errors++; $display("[TB] FAIL redirect_flush: got %b expected 11", flushVec); end
        checks++; if (stallVec !== 4'b0000) begin errors++; $display("[TB] FAIL redirect_stall: got %b expected 0000", stallVec); end
    endtask

    task automatic test_dram_wait();
        @(negedge clk); idleInputs(); mem_dram_req = 1; dram_ack = 1; #1;
        checks++; if (stallVec !== 4'b0000) begin errors++; $display("[TB] FAIL dram_single_stall: got %b expected 0000", stallVec); end
        @(negedge clk); idleInputs(); #1;
        checks++; if (stallVec !== 4'b0000) begin errors++; $display("[TB] FAIL dram_single_after: got %b expected 0000", stallVec); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); applyStimulus(); ex_redirect = 1;
            mem_dram_req = 1; dram_ack = (i == 3); #1;
            checks++; if (stallVec !== 4'b1111) begin errors++; $display("[TB] FAIL dram_wait_stall cycle %0d: got %b expected 1111", i, stallVec); end
            checks++; if ({flushVec, fwdVec} !== 8'b0) begin errors++; $display("[TB] FAIL dram_wait_quiet cycle %0d: got %b expected 00000000", i, {flushVec, fwdVec}); end
        end
        @(negedge clk); idleInputs(); ex_redirect = 1; #1;
        checks++; if (stallVec !== 4'b0000) begin errors++; $display("[TB] FAIL dram_done_stall: got %b expected 0000", stallVec); end
        checks++; if (flushVec !== 2'b11) begin errors++; $display("[TB] FAIL dram_done_redirect: got %b expected 11", flushVec); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("[TB] FAIL dram_done_timeout: got %b expected 0", mem_timeout); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i <= WAIT_MAX_TB; i++) begin
            @(negedge clk); idleInputs(); mem_dram_req = 1; #1;
            checks++; if ({stallVec, mem_timeout} !== 5'b1111_0) begin errors++; $display("[TB] FAIL timeout_wait cycle %0d: got %b expected 11110", i, {stallVec, mem_timeout}); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idleInputs(); mem_dram_req = (i == 0); dram_ack = (i == 2); #1;
            checks++; if ({stallVec, flushVec, mem_timeout} !== 7'b1111_00_1) begin errors++; $display("[TB] FAIL timeout_err cycle %0d: got %b expected 1111001", i, {stallVec, flushVec, mem_timeout}); end
        end
        @(negedge clk); idleInputs(); rst = 1; #1;
        checks++; if ({stallVec, flushVec} !== 6'b0000_11) begin errors++; $display("[TB] FAIL timeout_rst: got %b expected 000011", {stallVec, flushVec}); end
        @(negedge clk); #1;
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear: got %b expected 0", mem_timeout); end
        @(negedge clk); rst = 0; #1;
        checks++; if ({stallVec, flushVec, mem_timeout} !== 7'b0) begin errors++; $display("[TB] FAIL timeout_run: got %b expected 0000000", {stallVec, flushVec, mem_timeout}); end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        @(negedge clk); #1;
        checks++; if (perf_stall_cnt !== mStall) begin errors++; $display("[TB] FAIL perf_stall: got %0d expected %0d", perf_stall_cnt, mStall); end
        checks++; if (perf_flush_cnt !== mFlush) begin errors++; $display("[TB] FAIL perf_flush: got %0d expected %0d", perf_flush_cnt, mFlush); end
    endtask
`endif

    task automatic test_random(input int n);
        expect_t e;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 39) == 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_rs1_used  = ($urandom_range(0, 3) != 0);
            id_rs2_used  = ($urandom_range(0, 3) != 0);
            ex_wR        = 5'($urandom_range(0, 3));
            ex_rf_we     = ($urandom_range(0, 3) != 0);
            ex_is_load   = ($urandom_range(0, 2) == 0);
            mem_wR       = 5'($urandom_range(0, 3));
            mem_rf_we    = ($urandom_range(0, 3) != 0);
            wb_wR        = 5'($urandom_range(0, 3));
            wb_rf_we     = ($urandom_range(0, 3) != 0);
            ex_redirect  = ($urandom_range(0, 5) == 0);
            mem_dram_req = ($urandom_range(0, 4) == 0);
            dram_ack     = ($urandom_range(0, 2) == 0);
            #1;
            e = predict();
            checks++; if (stallVec !== e.stalls) begin errors++; $display("[TB] FAIL rand_stall cycle %0d: got %b expected %b", c, stallVec, e.stalls); end
            checks++; if (flushVec !== e.flushes) begin errors++; $display("[TB] FAIL rand_flush cycle %0d: got %b expected %b", c, flushVec, e.flushes); end
            checks++; if (fwdVec !== e.fwd) begin errors++; $display("[TB] FAIL rand_fwd cycle %0d: got %b expected %b", c, fwdVec, e.fwd); end
            checks++; if (mem_timeout !== mErr) begin errors++; $display("[TB] FAIL rand_timeout cycle %0d: got %b expected %b", c, mem_timeout, mErr); end
        end
        @(negedge clk); idleInputs(); rst = 0;
    endtask

    initial begin
        rst = 1;
        idleInputs();
        test_reset();
        test_forward_priority();
        test_load_use();
        test_redirect();
        test_dram_wait();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        test_timeout();
        test_load_use();
        test_redirect();
        test_dram_wait();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        test_random(400);
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
